// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, default widths,
// the HLT encoding and opcodes shared with the decode stage.
package fetch_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  localparam logic [31:0] HLT_WORD = 32'h0000_0000;

  // Opcode field values; ADD and SUB are R-type function codes.
  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counters.sv
// Bank of saturating event counters, one per bit of inc_i.
module fetch_perf_counters #(
  parameter int CNT_N = 3,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CNT_N-1:0]            inc_i,
  output logic [CNT_N-1:0][CNT_W-1:0] count_o
);

  generate
    for (genvar gi = 0; gi < CNT_N; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (inc_i[gi] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign count_o[gi] = cnt_q;
    end
  endgenerate

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses the synchronous ROM and
// pairs returned words with their PC. FETCH_PERF_CNT_EN adds perf counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] HLT_WORD = DATA_W'(fetch_pkg::HLT_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] direccion,
  input  logic [DATA_W-1:0] instruccion,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stalls,
  output logic [15:0]       perf_redirects,
`endif
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_START;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    if (redirect) begin
      state_d    = ST_RUN;
      pc_d       = redirect_pc;
      fetch_pc_d = redirect_pc + ADDR_W'(1);
      valid_d    = 1'b1;
    end else begin
      case (state_q)
        ST_START: begin
          if (!stall) begin
            state_d    = ST_RUN;
            pc_d       = RESET_PC;
            fetch_pc_d = RESET_PC + ADDR_W'(1);
            valid_d    = 1'b1;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            // The HLT word stays on the outputs; PC freezes on it.
            if (valid_out && (instruccion == HLT_WORD)) begin
              state_d = ST_HALT;
            end else begin
              pc_d       = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + ADDR_W'(1);
              valid_d    = 1'b1;
            end
          end
        end
        ST_HALT: ;
        default: state_d = ST_START;
      endcase
    end
  end

  // Holding the address at pc_q makes the ROM re-read the displayed word.
  always_comb begin
    if (redirect)                               direccion = redirect_pc;
    else if ((state_q == ST_HALT) || stall)     direccion = pc_q;
    else                                        direccion = fetch_pc_q;
  end

  assign valid_out = valid_q & ~redirect & (state_q == ST_RUN);
  assign pc_out    = pc_q;
  assign instr_out = valid_out ? instruccion : HLT_WORD;
  assign halted    = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [2:0][15:0] perf_cnt;

  fetch_perf_counters #(
    .CNT_N(3),
    .CNT_W(16)
  ) u_perf (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  ({redirect, (state_q == ST_RUN) & stall, valid_out & ~stall}),
    .count_o(perf_cnt)
  );

  assign perf_fetched   = perf_cnt[0];
  assign perf_stalls    = perf_cnt[1];
  assign perf_redirects = perf_cnt[2];
`endif

endmodule
